icache_dm: RTL and testbench
============================

Name: icache_dm

Overview:
- Direct-mapped, read-only instruction cache directly upstream of the pipelined datapath's Fetch stage.
- Consumes the Fetch-stage PC (pcF) and produces InstrF for the F->D pipeline register.
- On a miss it holds a stall request (to the hazard unit) and fills one line from a slower, handshaked instruction memory.
- Hits are combinational (0-cycle), so the single-cycle-fetch timing of the datapath is preserved.

Parameters:
- LINES, 16, number of cache lines; power of 2, >=2
- WORDS, 4, 32-bit words per line; power of 2, >=2
- NOP, 32'h0000_0013, instruction driven on a miss (addi x0,x0,0)

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- pcF  in  32  Fetch PC; bits [1:0] ignored
- InstrF  out  32  instruction at pcF on a hit, NOP otherwise
- CacheStallF  out  1  miss in progress; hazard unit ORs this into StallF and drives FlushD
- Invalidate  in  1  one-cycle pulse (fence.i): clear all valid bits
- MemReq  out  1  word read request, level-held
- MemAddr  out  32  word-aligned read address, stable while MemReq=1
- MemRValid  in  1  read data valid for the current MemAddr
- MemRData  in  32  read data

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-high, ports named clk and rst.
- Address split:
  - offset = pcF[OFFW+1:2], where OFFW = log2(WORDS)
  - index = next log2(LINES) bits
  - tag = remaining upper bits
- Hit = valid[index] && tag_arr[index]==tag && state==IDLE. Hit is purely combinational.
- On a hit, InstrF = data[index][offset]. Otherwise InstrF = NOP.
- CacheStallF = !hit (combinational). It is therefore 1 during reset and during FILL.
- FSM states IDLE, FILL:
  - IDLE, no hit, no Invalidate:
    - latch line base {tag,index,0} into fill_base and index into fill_idx
    - cnt <= 0, discard <= 0, go to FILL
  - FILL:
    - MemReq=1, MemAddr = fill_base + cnt*4
    - Each cycle with MemRValid=1: write MemRData into data[fill_idx][cnt], cnt++
    - On the WORDS-th word:
      - valid[fill_idx] <= !discard, tag_arr[fill_idx] <= fill tag
      - MemReq drops the next cycle; go to IDLE
  - Earliest hit on a refilled line: the cycle after return to IDLE.
- MemRValid while MemReq=0 is ignored.
- Memory latency is arbitrary (>=1 cycle per word). Words are requested strictly in order, with no critical-word-first.
- Miss penalty = 1 (detect) + sum of per-word latencies cycles.
- pcF may change during FILL (a branch redirect overrides StallF):
  - the fill completes to the latched line, unaffected
  - after return to IDLE, lookup uses the current pcF and may miss again
- Invalidate:
  - clears all valid bits the following edge
  - in FILL, it also sets discard, so the completing line is left invalid
  - Invalidate in the same cycle as the final fill word: valid bit ends 0
  - Invalidate in IDLE on a miss cycle: invalidation takes priority, no fill starts that cycle
- Reset (async, any state, including mid-fill):
  - state=IDLE, MemReq=0, MemAddr=0, cnt=0, discard=0, all valid=0
  - data and tag arrays are not reset
  - any MemRValid arriving after reset is ignored
- Widths: MemAddr wraps modulo 2^32. cnt is OFFW bits wide and is not reused after the last word.

Decomposition:
- Shared package icache_pkg:
  - state enum {IDLE, FILL}
  - NOP_INSTR constant
  - helper functions for offset/index/tag extraction from LINES, WORDS
- One natural sub-module, icache_data_ram:
  - LINES*WORDS x 32 array
  - asynchronous read (index, offset), synchronous write (fill_idx, cnt, MemRData, we)
- Valid/tag arrays and the FSM stay in icache_dm.

Test Plan:
- Cold miss: reset, pcF=0x0, memory latency 2 returning 0x00500093, 0x00600113, 0x002081B3, 0x00000013 -> CacheStallF=1 and InstrF=NOP for 1+4*2=9 cycles, MemAddr steps 0x0, 0x4, 0x8, 0xC; on the 10th cycle InstrF=0x00500093 and CacheStallF=0.
- Hits: after cold fill, pcF=0x4, 0x8, 0xC -> InstrF=0x00600113, 0x002081B3, 0x00000013 in the same cycle, MemReq=0 throughout.
- Conflict eviction: pcF=0x100 (index 0, tag 1) -> miss and fill from 0x100..0x10C; then pcF=0x0 -> misses again.
- Invalidate: pulse Invalidate mid-fill of line 0 -> fill completes (4 MemReq words) but the following lookup of pcF=0x0 misses; pulse in IDLE -> all previously valid lines miss.
- Redirect mid-fill: during fill of 0x0, change pcF to 0x40 -> fill of line 0 completes, then a new fill starts at 0x40; a later pcF=0x0 hits.
- Reset mid-fill: assert rst after 2 words -> MemReq=0 immediately; late MemRValid pulses are ignored; pcF=0x0 after reset misses and refetches from 0x0.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared types and address-split helpers for the direct-mapped instruction cache.
// Hit path is combinational; misses stall Fetch until one line is filled.
package icache_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Ceiling log2 written as a bounded loop so it folds to a constant.
  function automatic int unsigned log2u(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic logic [31:0] pcOffset(input logic [31:0] pc, input int unsigned words);
    return (pc >> 2) & (words - 1);
  endfunction

  function automatic logic [31:0] pcIndex(input logic [31:0] pc, input int unsigned words,
                                          input int unsigned lines);
    return (pc >> (2 + log2u(words))) & (lines - 1);
  endfunction

  function automatic logic [31:0] pcTag(input logic [31:0] pc, input int unsigned words,
                                        input int unsigned lines);
    return pc >> (2 + log2u(words) + log2u(lines));
  endfunction

endpackage

// File: rtl/icache_dm_if.sv
// Fetch-side and memory-side signals of the instruction cache.
// slave = cache view, master = fetch stage / memory view.
interface icache_dm_if;
  logic [31:0] pcF;
  logic [31:0] InstrF;
  logic        CacheStallF;
  logic        Invalidate;
  logic        MemReq;
  logic [31:0] MemAddr;
  logic        MemRValid;
  logic [31:0] MemRData;

  modport slave (
    input  pcF, Invalidate, MemRValid, MemRData,
    output InstrF, CacheStallF, MemReq, MemAddr
  );

  modport master (
    output pcF, Invalidate, MemRValid, MemRData,
    input  InstrF, CacheStallF, MemReq, MemAddr
  );
endinterface

// File: rtl/icache_data_ram.sv
// Line data store: asynchronous read for the 0-cycle hit path, one write per returned word.
// No backpressure; the writer presents at most one word per cycle.
module icache_data_ram
  import icache_pkg::*;
#(
  parameter int unsigned LINES = 16,
  parameter int unsigned WORDS = 4
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic [log2u(LINES)-1:0]   wIdx,
  input  logic [log2u(WORDS)-1:0]   wOff,
  input  logic [31:0]               wData,
  input  logic [log2u(LINES)-1:0]   rIdx,
  input  logic [log2u(WORDS)-1:0]   rOff,
  output logic [31:0]               rData
);

  logic [31:0] mem [LINES*WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[{wIdx, wOff}] <= wData;
  end

  assign rData = mem[{rIdx, rOff}];

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped read-only I-cache: 0-cycle hits, miss = 1 detect cycle + per-word memory latency.
// Stalls Fetch via CacheStallF while filling; memory side is a level-held request per word.
module icache_dm
  import icache_pkg::*;
#(
  parameter int unsigned LINES = 16,
  parameter int unsigned WORDS = 4,
  parameter logic [31:0] NOP   = NOP_INSTR
) (
  input logic        clk,
  input logic        rst,
  icache_dm_if.slave bus
);

  localparam int unsigned OFFW = log2u(WORDS);
  localparam int unsigned IDXW = log2u(LINES);
  localparam int unsigned TAGW = 32 - 2 - OFFW - IDXW;

  state_t            state, stateNext;
  logic [OFFW-1:0]   offset, cnt;
  logic [IDXW-1:0]   index, fillIdx;
  logic [TAGW-1:0]   tag, fillTag;
  logic [TAGW-1:0]   tagArr [LINES];
  logic [LINES-1:0]  validArr;
  logic [31:0]       fillBase, ramData;
  logic              hit, discard, startFill, lastWord, ramWe;

  assign offset = OFFW'(pcOffset(bus.pcF, WORDS));
  assign index  = IDXW'(pcIndex(bus.pcF, WORDS, LINES));
  assign tag    = TAGW'(pcTag(bus.pcF, WORDS, LINES));

  assign fillIdx = fillBase[OFFW+2 +: IDXW];
  assign fillTag = fillBase[31 -: TAGW];

  assign hit             = validArr[index] && (tagArr[index] == tag) && (state == IDLE);
  assign bus.InstrF      = hit ? ramData : NOP;
  assign bus.CacheStallF = !hit;

  // A pending invalidate wins over a miss, so no fill is launched that cycle.
  assign startFill = (state == IDLE) && !hit && !bus.Invalidate;
  assign lastWord  = (state == FILL) && bus.MemRValid && (cnt == OFFW'(WORDS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (startFill) stateNext = FILL;
      FILL:    if (lastWord)  stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    bus.MemReq  = 1'b0;
    bus.MemAddr = '0;
    ramWe       = 1'b0;
    if (state == FILL) begin
      bus.MemReq  = 1'b1;
      bus.MemAddr = fillBase + 32'({cnt, 2'b00});
      ramWe       = bus.MemRValid;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      discard  <= 1'b0;
      fillBase <= '0;
      validArr <= '0;
    end else begin
      if (startFill) begin
        fillBase <= {tag, index, {(OFFW + 2){1'b0}}};
        cnt      <= '0;
        discard  <= 1'b0;
      end
      if (ramWe) cnt <= cnt + 1'b1;
      if ((state == FILL) && bus.Invalidate) discard <= 1'b1;
      if (lastWord) validArr[fillIdx] <= !discard;
      // Later assignment lets a same-cycle invalidate override the fill's valid bit.
      if (bus.Invalidate) validArr <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (lastWord) tagArr[fillIdx] <= fillTag;
  end

  icache_data_ram #(
    .LINES (LINES),
    .WORDS (WORDS)
  ) dataRam (
    .clk   (clk),
    .we    (ramWe),
    .wIdx  (fillIdx),
    .wOff  (cnt),
    .wData (bus.MemRData),
    .rIdx  (index),
    .rOff  (offset),
    .rData (ramData)
  );

endmodule

// File: tb/tb_icache_dm.sv
// Bench for icache_dm: handshaked memory model plus a line-level reference of cache contents.
// Directed scenarios first, then randomized fetch sequences.
module tb_icache_dm;

  localparam int unsigned LINES = 16;
  localparam int unsigned WORDS = 4;
  localparam logic [31:0] NOPI  = 32'h0000_0013;
  localparam logic [31:0] LINEB = WORDS * 4;
  localparam logic [31:0] SPAN  = WORDS * 4 * LINES;

  logic clk;
  logic rst;
  icache_dm_if bus ();

  icache_dm #(.LINES(LINES), .WORDS(WORDS), .NOP(NOPI)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int compared = 0;
  int mismatched = 0;
  int memLat = 1;
  bit spurious = 1'b0;
  bit carry = 1'b0;
  logic [31:0] curPc = '0;
  bit refValid [LINES];
  logic [31:0] refTag [LINES];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memData(input logic [31:0] addr);
    case (addr)
      32'h0:   return 32'h0050_0093;
      32'h4:   return 32'h0060_0113;
      32'h8:   return 32'h0020_81B3;
      32'hC:   return 32'h0000_0013;
      default: return (addr * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endcase
  endfunction

  function automatic bit refHit(input logic [31:0] pc);
    logic [31:0] idx;
    idx = (pc / LINEB) % LINES;
    return refValid[idx] && (refTag[idx] == pc / SPAN);
  endfunction

  task automatic clearRef();
    for (int i = 0; i < LINES; i++) refValid[i] = 1'b0;
  endtask

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  // Memory: each requested word returns after memLat cycles of MemReq.
  initial begin
    int waitCnt;
    waitCnt = 0;
    bus.MemRValid = 1'b0;
    bus.MemRData  = '0;
    forever begin
      @(posedge clk);
      #2;
      bus.MemRValid = 1'b0;
      if (bus.MemReq) begin
        waitCnt++;
        if (waitCnt >= memLat) begin
          bus.MemRValid = 1'b1;
          bus.MemRData  = memData(bus.MemAddr);
          waitCnt = 0;
        end
      end else begin
        waitCnt = 0;
      end
      if (spurious) begin
        bus.MemRValid = 1'b1;
        bus.MemRData  = 32'hDEAD_BEEF;
      end
    end
  end

  // One lookup of pc; on a miss follows the fill to the cycle the cache returns to IDLE.
  task automatic fetch(input logic [31:0] pc, input int lat, input int invAt,
                       input int redirAt, input logic [31:0] redirPc);
    int n, got;
    logic [31:0] base, cur, idx;
    bit inv, hitNow;
    @(posedge clk);
    #1;
    rst = 1'b0;
    spurious = 1'b0;
    bus.pcF = pc;
    bus.Invalidate = 1'b0;
    memLat = lat;
    cur = pc;
    if (!carry && refHit(pc)) begin
      @(negedge clk);
      check("hitStall", 32'(bus.CacheStallF), 32'd0);
      check("hitInstr", bus.InstrF, memData(pc & ~32'h3));
      check("hitMemReq", 32'(bus.MemReq), 32'd0);
      curPc = pc;
      return;
    end
    base = pc - (pc % LINEB);
    got = 0;
    inv = 1'b0;
    n = 0;
    while (n < 64) begin
      if (n > 0) begin
        @(posedge clk);
        #1;
        bus.Invalidate = (n == invAt);
        if (n == redirAt) begin
          bus.pcF = redirPc;
          cur = redirPc;
        end
      end
      @(negedge clk);
      if (bus.Invalidate) inv = 1'b1;
      if (got == WORDS) break;
      check("missStall", 32'(bus.CacheStallF), 32'd1);
      check("missInstr", bus.InstrF, NOPI);
      if (bus.MemReq) check("fillAddr", bus.MemAddr, base + 32'(got) * 4);
      if (bus.MemReq && bus.MemRValid) got++;
      n++;
    end
    check("fillWords", 32'(got), 32'(WORDS));
    check("missCycles", 32'(n), 32'((carry ? 0 : 1) + WORDS * lat));
    idx = (pc / LINEB) % LINES;
    if (inv) clearRef();
    else begin
      refValid[idx] = 1'b1;
      refTag[idx] = pc / SPAN;
    end
    hitNow = refHit(cur);
    check("returnStall", 32'(bus.CacheStallF), 32'(!hitNow));
    if (hitNow) check("returnInstr", bus.InstrF, memData(cur & ~32'h3));
    check("returnMemReq", 32'(bus.MemReq), 32'd0);
    carry = !hitNow;
    curPc = cur;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int got, lat, invAt;
    logic [31:0] pc;
    rst = 1'b1;
    bus.pcF = '0;
    bus.Invalidate = 1'b0;
    clearRef();

    // Reset state
    @(negedge clk);
    check("rstStall", 32'(bus.CacheStallF), 32'd1);
    check("rstMemReq", 32'(bus.MemReq), 32'd0);
    check("rstMemAddr", bus.MemAddr, 32'd0);
    check("rstInstr", bus.InstrF, NOPI);

    // Cold miss with latency 2, then same-line hits
    fetch(32'h0, 2, -1, -1, '0);
    fetch(32'h4, 1, -1, -1, '0);
    fetch(32'h8, 1, -1, -1, '0);
    fetch(32'hC, 1, -1, -1, '0);

    // Conflict eviction on index 0
    fetch(32'h100, 1, -1, -1, '0);
    fetch(32'h0, 1, -1, -1, '0);

    // Invalidate mid-fill of line 0, then refill
    fetch(32'h100, 1, -1, -1, '0);
    fetch(32'h0, 2, 3, -1, '0);
    fetch(32'h0, 1, -1, -1, '0);

    // Invalidate on the cycle of the final word
    fetch(32'h10, 2, 8, -1, '0);
    fetch(32'h10, 1, -1, -1, '0);
    fetch(32'h0, 1, -1, -1, '0);

    // Invalidate in IDLE on a miss cycle blocks that cycle's fill
    @(posedge clk);
    #1;
    bus.pcF = 32'h500;
    bus.Invalidate = 1'b1;
    @(negedge clk);
    check("invIdleStall", 32'(bus.CacheStallF), 32'd1);
    check("invIdleMemReq", 32'(bus.MemReq), 32'd0);
    @(posedge clk);
    #1;
    bus.Invalidate = 1'b0;
    @(negedge clk);
    check("invIdleNoFill", 32'(bus.MemReq), 32'd0);
    clearRef();
    carry = 1'b1;
    fetch(32'h500, 1, -1, -1, '0);
    fetch(32'h10, 1, -1, -1, '0);

    // Redirect mid-fill
    fetch(32'h0, 2, -1, 3, 32'h40);
    fetch(32'h40, 1, -1, -1, '0);
    fetch(32'h0, 1, -1, -1, '0);

    // Reset mid-fill after two words, with late MemRValid pulses
    @(posedge clk);
    #1;
    bus.pcF = 32'h300;
    memLat = 1;
    got = 0;
    for (int k = 0; k < 20 && got < 2; k++) begin
      @(negedge clk);
      if (bus.MemReq && bus.MemRValid) got++;
    end
    check("preResetWords", 32'(got), 32'd2);
    rst = 1'b1;
    spurious = 1'b1;
    #1;
    check("midRstMemReq", 32'(bus.MemReq), 32'd0);
    check("midRstMemAddr", bus.MemAddr, 32'd0);
    check("midRstStall", 32'(bus.CacheStallF), 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rstHoldMemReq", 32'(bus.MemReq), 32'd0);
    end
    clearRef();
    carry = 1'b0;
    fetch(32'h0, 2, -1, -1, '0);

    // Top of the address space
    fetch(32'hFFFF_FFF0, 1, -1, -1, '0);
    fetch(32'hFFFF_FFFC, 3, -1, -1, '0);

    // Randomized fetch stream with occasional invalidates
    for (int i = 0; i < 40; i++) begin
      lat = int'($urandom_range(1, 3));
      pc = carry ? curPc : 32'($urandom_range(0, 255)) * 4;
      invAt = -1;
      if (!carry && ($urandom_range(0, 5) == 0)) invAt = int'($urandom_range(1, WORDS * lat));
      fetch(pc, lat, invAt, -1, '0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
